uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//  Frame sequencer of the UART transmitter. Accepts a byte via a valid pulse and drives LOAD/SHIFT of the
//  downstream Shift_Register. Muxes start bit, the register's serial DATA_OUT, optional parity and stop bit
//  onto TX_OUT. Contains its own baud prescaler, so each symbol lasts exactly CLKS_PER_BIT clocks.
// PARAMETERS
//  CLKS_PER_BIT  16  clocks per UART symbol; legal range >= 2
//  DATA_W         8  data bits per frame; must match the shift register width
//  PAR_ODD        0  0 = even parity, 1 = odd parity (used only when UART_TX_PARITY_EN is defined)
// PORTS
//  CLK         in   1       system clock; all state updates on posedge
//  RST         in   1       asynchronous, active-high reset
//  DATA_VALID  in   1       request to send P_DATA; sampled only in IDLE
//  P_DATA      in   DATA_W  parallel byte; also feeds the shift register DATA_IN
//  SER_DATA    in   1       serial bit from shift register DATA_OUT (LSB first)
//  LOAD        out  1       load strobe to shift register
//  SHIFT       out  1       shift strobe to shift register
//  TX_OUT      out  1       UART line; idle-high
//  BUSY        out  1       frame in progress
//  DONE        out  1       one-cycle pulse marking the last clock of the stop bit
// BEHAVIOUR
//  Reset (async, RST=1): state=IDLE, counters=0, parity reg=0, LOAD=0, SHIFT=0, BUSY=0, DONE=0, TX_OUT=1.
//  Registered state: IDLE, START, DATA, PARITY, STOP.
//  baud_cnt: $clog2(CLKS_PER_BIT) bits. bit_idx: $clog2(DATA_W) bits.
//  tick = (baud_cnt == CLKS_PER_BIT-1). baud_cnt clears on entry to each non-IDLE state, else increments.
//  IDLE: LOAD = DATA_VALID (combinational, same cycle). On that edge: shift reg captures P_DATA,
//    parity reg <= ^P_DATA ^ PAR_ODD, next state = START.
//  START: lasts CLKS_PER_BIT cycles; on tick -> DATA with bit_idx=0.
//  DATA: on tick, SHIFT=1 for that one cycle and bit_idx increments.
//    When tick and bit_idx==DATA_W-1: -> PARITY if parity is enabled, else -> STOP.
//    SHIFT fires exactly DATA_W times per frame, never outside DATA.
//  PARITY: lasts CLKS_PER_BIT cycles, then -> STOP.
//  STOP: lasts CLKS_PER_BIT cycles; DONE=1 on the tick cycle, then -> IDLE.
//  TX_OUT is decoded from the registered state (SER_DATA is itself a register bit, so no glitch):
//    IDLE=1, START=0, DATA=SER_DATA, PARITY=parity reg, STOP=1.
//  BUSY=1 in every state except IDLE.
//  Latency: TX_OUT falls on the first edge after the accept edge.
//  Frame length is (DATA_W+2[+1]) * CLKS_PER_BIT clocks; the optional +1 symbol is the parity bit.
//  DATA_VALID while BUSY is ignored, with no queueing.
//  Back-to-back frames: at least one IDLE cycle separates them (accept is possible the cycle after DONE).
//  P_DATA need only be stable during the accept cycle.
//  RST asserted mid-frame aborts immediately: TX_OUT=1 and no further LOAD/SHIFT.
//  The shift register is reset by the same RST.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state is present, frame = start + DATA_W + parity + stop.
//  UART_TX_PARITY_EN undefined: PARITY state and parity reg are removed, DATA -> STOP directly,
//    PAR_ODD has no effect.
// TESTING (CLKS_PER_BIT=4, DATA_W=8, TX_OUT sampled mid-symbol)
//  1 Reset: RST=1 at any point -> TX_OUT=1, BUSY=0, LOAD=SHIFT=DONE=0. Hold idle 20 clks -> TX_OUT stays 1.
//  2 No parity: send 0xA5.
//    -> LOAD=1 for exactly 1 clk. TX_OUT symbols 0,1,0,1,0,0,1,0,1,1.
//    -> BUSY high 40 clks, 8 SHIFT pulses 4 clks apart, DONE on clk 40.
//  3 Parity enabled, PAR_ODD=0: send 0xA5 -> parity symbol 0, frame 44 clks.
//    PAR_ODD=1 with 0x01 -> parity symbol 0. PAR_ODD=0 with 0x01 -> parity symbol 1.
//  4 DATA_VALID pulses with 0xFF mid-frame of a 0x00 frame -> ignored, line shows 0x00 only.
//    DATA_VALID held high continuously -> next START begins 1 clk after DONE.
//  5 RST pulse during DATA bit 3 -> TX_OUT=1 asynchronously, state IDLE.
//    Next DATA_VALID with 0x3C -> clean full 0x3C frame.
//  6 Boundary: CLKS_PER_BIT=2, send 0x80 and 0x00 -> every symbol exactly 2 clks, MSB=1 in the last data slot.

Source files
------------

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: byte request, shift-register strobes and line outputs
// of the UART transmit frame sequencer.
interface uart_tx_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              DATA_VALID;
  logic [DATA_W-1:0] P_DATA;
  logic              SER_DATA;
  logic              LOAD;
  logic              SHIFT;
  logic              TX_OUT;
  logic              BUSY;
  logic              DONE;

  modport master (
    output DATA_VALID, P_DATA, SER_DATA,
    input  LOAD, SHIFT, TX_OUT, BUSY, DONE
  );

  modport slave (
    input  DATA_VALID, P_DATA, SER_DATA,
    output LOAD, SHIFT, TX_OUT, BUSY, DONE
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer with its own baud prescaler.
// Define UART_TX_PARITY_EN to insert a parity symbol before the stop bit.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter bit PAR_ODD      = 1'b0
) (
  input logic           CLK,
  input logic           RST,
  uart_tx_ctrl_if.slave bus
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] baud_cnt;
  logic [IW-1:0] bit_idx;
  logic          tick;
  logic          accept;
  logic          last_bit;
  logic          par_bit;

  assign tick     = (baud_cnt == LAST_CNT);
  assign last_bit = (bit_idx == LAST_BIT);
  assign accept   = (state == IDLE) & bus.DATA_VALID & ~RST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // every non-idle transition happens on tick, so clearing on tick
  // restarts the symbol timer on entry to each state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      baud_cnt <= '0;
    end else if (state == IDLE || tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_idx <= '0;
    end else if (state == START) begin
      bit_idx <= '0;
    end else if (state == DATA && tick) begin
      bit_idx <= bit_idx + 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_bit <= 1'b0;
    end else if (accept) begin
      par_bit <= (^bus.P_DATA) ^ PAR_ODD;
    end
  end
`else
  logic unused_par_odd;
  assign unused_par_odd = PAR_ODD;
  assign par_bit        = 1'b1;
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) nxt = START;
      end
      START: begin
        if (tick) nxt = DATA;
      end
      DATA: begin
        if (tick && last_bit) begin
`ifdef UART_TX_PARITY_EN
          nxt = PARITY;
`else
          nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) nxt = STOP;
      end
`endif
      STOP: begin
        if (tick) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // line is decoded from registered state only; SER_DATA is a flop output
  always_comb begin
    bus.LOAD   = accept;
    bus.SHIFT  = 1'b0;
    bus.DONE   = 1'b0;
    bus.BUSY   = 1'b1;
    bus.TX_OUT = 1'b1;
    unique case (state)
      IDLE: begin
        bus.BUSY = 1'b0;
      end
      START: begin
        bus.TX_OUT = 1'b0;
      end
      DATA: begin
        bus.TX_OUT = bus.SER_DATA;
        bus.SHIFT  = tick;
      end
      PARITY: begin
        bus.TX_OUT = par_bit;
      end
      STOP: begin
        bus.DONE = tick;
      end
      default: begin
        bus.BUSY = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: two sequencers (4 and 2 clks/bit, even and odd parity)
// checked each cycle against a frame-level model plus literal frames.
module tb_uart_tx_ctrl;
  localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NS = DW + 3;
  localparam logic [NS-1:0] A5_E = 11'b1_0_10100101_0;
  localparam logic [NS-1:0] A5_O = 11'b1_1_10100101_0;
  localparam logic [NS-1:0] X01_E = 11'b1_1_00000001_0;
  localparam logic [NS-1:0] X01_O = 11'b1_0_00000001_0;
  localparam logic [NS-1:0] X80_E = 11'b1_1_10000000_0;
  localparam logic [NS-1:0] X80_O = 11'b1_0_10000000_0;
  localparam logic [NS-1:0] X00_E = 11'b1_0_00000000_0;
  localparam logic [NS-1:0] X00_O = 11'b1_1_00000000_0;
  localparam logic [NS-1:0] X3C_E = 11'b1_0_00111100_0;
  localparam logic [NS-1:0] X3C_O = 11'b1_1_00111100_0;
`else
  localparam int NS = DW + 2;
  localparam logic [NS-1:0] A5_E = 10'b1_10100101_0;
  localparam logic [NS-1:0] A5_O = A5_E;
  localparam logic [NS-1:0] X01_E = 10'b1_00000001_0;
  localparam logic [NS-1:0] X01_O = X01_E;
  localparam logic [NS-1:0] X80_E = 10'b1_10000000_0;
  localparam logic [NS-1:0] X80_O = X80_E;
  localparam logic [NS-1:0] X00_E = 10'b1_00000000_0;
  localparam logic [NS-1:0] X00_O = X00_E;
  localparam logic [NS-1:0] X3C_E = 10'b1_00111100_0;
  localparam logic [NS-1:0] X3C_O = X3C_E;
`endif
  localparam int FL0 = NS * 4;
  localparam int FL1 = NS * 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          dv;
  logic [DW-1:0] pd;
  int            vec = 0;
  int            err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int CPB = (g == 0) ? 4 : 2;
    localparam bit PO  = (g == 0) ? 1'b0 : 1'b1;
    localparam int FL  = NS * CPB;

    uart_tx_ctrl_if #(.DATA_W(DW)) u_if ();

    uart_tx_ctrl #(
      .CLKS_PER_BIT(CPB),
      .DATA_W(DW),
      .PAR_ODD(PO)
    ) u_dut (
      .CLK(clk),
      .RST(rst),
      .bus(u_if.slave)
    );

    logic [DW-1:0] sr;
    assign u_if.DATA_VALID = dv;
    assign u_if.P_DATA     = pd;
    assign u_if.SER_DATA   = sr[0];

    always @(posedge clk or posedge rst) begin
      if (rst) sr <= '0;
      else if (u_if.LOAD) sr <= pd;
      else if (u_if.SHIFT) sr <= sr >> 1;
    end

    // model: a frame is NS symbols of CPB clocks, m_t counts clocks in it
    logic          m_busy;
    int            m_t;
    logic [NS-1:0] m_sym;
    int            gvec = 0;
    int            gerr = 0;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_busy <= 1'b0;
        m_t    <= 0;
      end else if (!m_busy) begin
        if (dv) begin
          m_busy <= 1'b1;
          m_t    <= 0;
`ifdef UART_TX_PARITY_EN
          m_sym  <= {1'b1, (^pd) ^ PO, pd, 1'b0};
`else
          m_sym  <= {1'b1, pd, 1'b0};
`endif
        end
      end else if (m_t == FL - 1) begin
        m_busy <= 1'b0;
      end else begin
        m_t <= m_t + 1;
      end
    end

    always @(negedge clk) begin
      int k;
      int ph;
      logic [4:0] e;
      logic [4:0] a;
      k  = m_t / CPB;
      ph = m_t % CPB;
      e[4] = m_busy ? m_sym[k] : 1'b1;
      e[3] = m_busy;
      e[2] = m_busy && (m_t == FL - 1);
      e[1] = m_busy && k >= 1 && k <= DW && ph == CPB - 1;
      e[0] = !m_busy && dv && !rst;
      a = {u_if.TX_OUT, u_if.BUSY, u_if.DONE, u_if.SHIFT, u_if.LOAD};
      gvec++;
      if (a !== e) begin
        gerr++;
        $display("FAIL cyc dut%0d t=%0t tx/busy/done/shift/load got %b want %b",
                 g, $time, a, e);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [NS-1:0] act,
                      input logic [NS-1:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input bit noise,
                      input logic [NS-1:0] e0, input logic [NS-1:0] e1);
    logic [NS-1:0] s0;
    logic [NS-1:0] s1;
    int nb;
    int n0;
    int n1;
    int di;
    int nl;
    s0 = '0;
    s1 = '0;
    nb = 0;
    n0 = 0;
    n1 = 0;
    di = -1;
    nl = 0;
    @(posedge clk); #1;
    dv = 1'b1;
    pd = d;
    @(negedge clk);
    if (gen_dut[0].u_if.LOAD) nl++;
    @(posedge clk); #1;
    dv = 1'b0;
    pd = DW'($urandom);
    for (int i = 0; i < FL0 + 2; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        if (noise && i < FL1 - 2 && i % 5 == 3) begin
          dv = 1'b1;
          pd = 8'hFF;
        end else begin
          dv = 1'b0;
        end
      end
      @(negedge clk);
      if (gen_dut[0].u_if.BUSY) nb++;
      if (gen_dut[0].u_if.SHIFT) n0++;
      if (gen_dut[1].u_if.SHIFT) n1++;
      if (gen_dut[0].u_if.LOAD) nl++;
      if (gen_dut[0].u_if.DONE) di = i;
      if (i % 4 == 2 && i / 4 < NS) s0[i/4] = gen_dut[0].u_if.TX_OUT;
      if (i % 2 == 1 && i / 2 < NS) s1[i/2] = gen_dut[1].u_if.TX_OUT;
    end
    dv = 1'b0;
    chkv("frame4", s0, e0);
    chkv("frame2", s1, e1);
    chk("busy_len", nb, FL0);
    chk("shifts4", n0, DW);
    chk("shifts2", n1, DW);
    chk("done_at", di, FL0 - 1);
    chk("loads", nl, 1);
  endtask

  initial begin
    bit hold;
    rst = 1'b1;
    dv  = 1'b1;
    pd  = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", gen_dut[0].u_if.TX_OUT, 1);
    chk("rst_busy", gen_dut[0].u_if.BUSY, 0);
    chk("rst_load", gen_dut[0].u_if.LOAD, 0);
    chk("rst_shift", gen_dut[0].u_if.SHIFT, 0);
    chk("rst_done", gen_dut[0].u_if.DONE, 0);
    dv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_tx", gen_dut[0].u_if.TX_OUT, 1);
    end

    send(8'hA5, 1'b0, A5_E, A5_O);
    send(8'h01, 1'b0, X01_E, X01_O);
    send(8'h80, 1'b0, X80_E, X80_O);
    send(8'h00, 1'b1, X00_E, X00_O);

    // DATA_VALID held high: restart one clock after DONE
    @(posedge clk); #1;
    dv = 1'b1;
    pd = 8'hA5;
    @(posedge clk);
    for (int i = 0; i < FL0 + 2; i++) begin
      @(negedge clk);
      if (i == FL0 - 1) chk("hold_done", gen_dut[0].u_if.DONE, 1);
      if (i == FL0) begin
        chk("hold_gap_busy", gen_dut[0].u_if.BUSY, 0);
        chk("hold_gap_load", gen_dut[0].u_if.LOAD, 1);
      end
      if (i == FL0 + 1) begin
        chk("hold_rstart_busy", gen_dut[0].u_if.BUSY, 1);
        chk("hold_rstart_tx", gen_dut[0].u_if.TX_OUT, 0);
      end
    end
    dv = 1'b0;
    repeat (FL0 + 4) @(posedge clk);

    // reset during data bit 3 of the 4-clk unit
    @(posedge clk); #1;
    dv = 1'b1;
    pd = 8'hC3;
    @(posedge clk); #1;
    dv = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_tx", gen_dut[0].u_if.TX_OUT, 1);
    chk("abort_busy", gen_dut[0].u_if.BUSY, 0);
    chk("abort_tx2", gen_dut[1].u_if.TX_OUT, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    send(8'h3C, 1'b0, X3C_E, X3C_O);

    hold = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if ($urandom % 50 == 0) hold = ~hold;
      dv = hold | ($urandom % 6 == 0);
      pd = DW'($urandom);
      if ($urandom % 400 == 0) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
    end
    dv = 1'b0;
    repeat (FL0 + 4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec + gen_dut[0].gvec + gen_dut[1].gvec,
             err + gen_dut[0].gerr + gen_dut[1].gerr);
    $finish;
  end
endmodule
